// File: rtl/wb_regfile_pkg.sv
// Shared MIPS opcode/funct constants, register indices and the writeback source select type
// used by the W-stage writeback and register file.
package wb_regfile_pkg;

    localparam logic [31:0] SpInit = 32'h0000_2ffc;
    localparam logic [31:0] GpInit = 32'h0000_1800;

    localparam logic [4:0] RegRa = 5'd31;
    localparam logic [4:0] RegSp = 5'd29;
    localparam logic [4:0] RegGp = 5'd28;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpSltiu = 6'h0b;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpCop0  = 6'h10;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpLh    = 6'h21;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpLbu   = 6'h24;
    localparam logic [5:0] OpLhu   = 6'h25;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnMfhi = 6'h10;
    localparam logic [5:0] FnMflo = 6'h12;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2a;
    localparam logic [5:0] FnSltu = 6'h2b;

    typedef enum logic [2:0] {
        WbNone,
        WbAlu,
        WbHi,
        WbLo,
        WbLink,
        WbLoad,
        WbCp0
    } wb_sel_e;

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian sub-word extraction of a loaded memory word (lb/lbu/lh/lhu/lw).
module wb_load_ext
    import wb_regfile_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        // Halfword position ignores offset bit 0; misalignment is trapped upstream.
        half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
        unique case (opcode_i)
            OpLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   data_o = {24'h0, byte_sel};
            OpLh:    data_o = {{16{half_sel[15]}}, half_sel};
            OpLhu:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: decodes the W instruction, forms the writeback value and commits it to the
// 32x32 register file, which serves two read ports with same-cycle write-through bypass.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrW,
    input  logic [29:0] PCW,
    input  logic [31:0] AluOutW,
    input  logic [31:0] MemOutW,
    input  logic [31:0] HiOutW,
    input  logic [31:0] LoOutW,
    input  logic [31:0] CP0outW,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] link;
    logic [31:0] load_data;
    wb_sel_e     wb_sel;
    logic        unused_shamt;

    assign op           = InstrW[31:26];
    assign rs           = InstrW[25:21];
    assign rt           = InstrW[20:16];
    assign rd           = InstrW[15:11];
    assign funct        = InstrW[5:0];
    assign unused_shamt = ^InstrW[10:6];
    assign link         = {PCW + 30'd2, 2'b00};

    wb_load_ext u_load_ext (
        .opcode_i (op),
        .offset_i (AluOutW[1:0]),
        .word_i   (MemOutW),
        .data_o   (load_data)
    );

    always_comb begin
        wb_sel  = WbNone;
        wb_addr = rt;
        unique case (op)
            OpRtype: begin
                wb_addr = rd;
                unique case (funct)
                    FnMfhi: wb_sel = WbHi;
                    FnMflo: wb_sel = WbLo;
                    FnJalr: wb_sel = WbLink;
                    FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav,
                    FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
                    FnSlt, FnSltu: wb_sel = WbAlu;
                    default: wb_sel = WbNone;
                endcase
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: wb_sel = WbAlu;
            OpJal: begin
                wb_addr = RegRa;
                wb_sel  = WbLink;
            end
            OpLb, OpLh, OpLw, OpLbu, OpLhu: wb_sel = WbLoad;
            OpCop0: wb_sel = (rs == 5'd0) ? WbCp0 : WbNone;
            default: wb_sel = WbNone;
        endcase
    end

    always_comb begin
        unique case (wb_sel)
            WbHi:    wb_data = HiOutW;
            WbLo:    wb_data = LoOutW;
            WbLink:  wb_data = link;
            WbLoad:  wb_data = load_data;
            WbCp0:   wb_data = CP0outW;
            default: wb_data = AluOutW;
        endcase
        wb_we = (wb_sel != WbNone) && (wb_addr != 5'd0) && !rst;
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                if (5'(i) == RegGp) begin
                    regs_q[i] <= GpInit;
                end else if (5'(i) == RegSp) begin
                    regs_q[i] <= SpInit;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // $0 is hardwired; a matching in-flight write is forwarded ahead of storage.
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (wb_we && (raddr1 == wb_addr)) begin
            rdata1 = wb_data;
        end else begin
            rdata1 = regs_q[raddr1];
        end
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (wb_we && (raddr2 == wb_addr)) begin
            rdata2 = wb_data;
        end else begin
            rdata2 = regs_q[raddr2];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a table of W-stage instructions checked on the bypass path
// in the issuing cycle and, via a scoreboard queue, from storage one cycle later.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] InstrW;
    logic [29:0] PCW;
    logic [31:0] AluOutW;
    logic [31:0] MemOutW;
    logic [31:0] HiOutW;
    logic [31:0] LoOutW;
    logic [31:0] CP0outW;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    wb_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .InstrW  (InstrW),
        .PCW     (PCW),
        .AluOutW (AluOutW),
        .MemOutW (MemOutW),
        .HiOutW  (HiOutW),
        .LoOutW  (LoOutW),
        .CP0outW (CP0outW),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [29:0] pcw;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cp0;
        logic        we;
        logic        dec;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  chk;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        InstrW  = 32'h0;
        PCW     = 30'h0;
        AluOutW = 32'h0;
        MemOutW = 32'h0;
        HiOutW  = 32'h0;
        LoOutW  = 32'h0;
        CP0outW = 32'h0;
    endtask

    task automatic apply_vec(input vec_t v);
        sb_t item;
        @(negedge clk);
        InstrW  = v.instr;
        PCW     = v.pcw;
        AluOutW = v.alu;
        MemOutW = v.mem;
        HiOutW  = v.hi;
        LoOutW  = v.lo;
        CP0outW = v.cp0;
        raddr1  = v.chk;
        raddr2  = v.chk;
        #2;
        check({v.name, ".we"}, {31'h0, wb_we}, {31'h0, v.we});
        if (v.dec) begin
            check({v.name, ".addr"}, {27'h0, wb_addr}, {27'h0, v.addr});
            check({v.name, ".data"}, wb_data, v.data);
        end
        check({v.name, ".byp1"}, rdata1, v.rd);
        check({v.name, ".byp2"}, rdata2, v.rd);
        item.name = v.name;
        item.addr = v.chk;
        item.data = v.rd;
        sb_q.push_back(item);
        @(negedge clk);
        drive_nop();
        raddr1 = sb_q[0].addr;
        raddr2 = 5'd0;
        #2;
        item = sb_q.pop_front();
        check({item.name, ".stored"}, rdata1, item.data);
    endtask

    initial begin
        // name, instr, pcw, alu, mem, hi, lo, cp0, we, dec, addr, data, chk, rd
        vecs.push_back('{"addiu8", 32'h2408_0005, 30'h0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd8, 32'h5, 5'd8, 32'h5});
        vecs.push_back('{"lb9", 32'h8009_0001, 30'h0, 32'h1, 32'h1234_80ff, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd9, 32'hffff_ff80, 5'd9, 32'hffff_ff80});
        vecs.push_back('{"lbu10", 32'h900a_0001, 30'h0, 32'h1, 32'h1234_80ff, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd10, 32'h0000_0080, 5'd10, 32'h0000_0080});
        vecs.push_back('{"lhu11", 32'h940b_0002, 30'h0, 32'h2, 32'h1234_80ff, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd11, 32'h0000_1234, 5'd11, 32'h0000_1234});
        vecs.push_back('{"lh12", 32'h840c_0000, 30'h0, 32'h100, 32'h1234_80ff, 32'h0, 32'h0,
                         32'h0, 1'b1, 1'b1, 5'd12, 32'hffff_80ff, 5'd12, 32'hffff_80ff});
        vecs.push_back('{"lw13", 32'h8c0d_0004, 30'h0, 32'h4, 32'h1234_80ff, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd13, 32'h1234_80ff, 5'd13, 32'h1234_80ff});
        vecs.push_back('{"lb14off3", 32'h800e_0003, 30'h0, 32'h3, 32'h1234_80ff, 32'h0, 32'h0,
                         32'h0, 1'b1, 1'b1, 5'd14, 32'h0000_0012, 5'd14, 32'h0000_0012});
        vecs.push_back('{"jal", 32'h0c00_0100, 30'h0000_0c00, 32'hdead_beef, 32'h0, 32'h0, 32'h0,
                         32'h0, 1'b1, 1'b1, 5'd31, 32'h0000_3008, 5'd31, 32'h0000_3008});
        vecs.push_back('{"jalr4", 32'h03e0_2009, 30'h0000_0c10, 32'hdead_beef, 32'h0, 32'h0,
                         32'h0, 32'h0, 1'b1, 1'b1, 5'd4, 32'h0000_3048, 5'd4, 32'h0000_3048});
        vecs.push_back('{"addu0", 32'h0109_0021, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b1, 5'd0, 32'hdead_beef, 5'd0, 32'h0});
        vecs.push_back('{"sw", 32'hac08_0000, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 32'h5});
        vecs.push_back('{"jr", 32'h03e0_0008, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 32'h0000_3008});
        vecs.push_back('{"mfhi3", 32'h0000_1810, 30'h0, 32'hdead_beef, 32'h0, 32'h1111_1111,
                         32'h0, 32'h0, 1'b1, 1'b1, 5'd3, 32'h1111_1111, 5'd3, 32'h1111_1111});
        vecs.push_back('{"mflo6", 32'h0000_3012, 30'h0, 32'hdead_beef, 32'h0, 32'h0,
                         32'h2222_3333, 32'h0, 1'b1, 1'b1, 5'd6, 32'h2222_3333, 5'd6,
                         32'h2222_3333});
        vecs.push_back('{"mfc0_7", 32'h4007_6000, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0,
                         32'h0000_0013, 1'b1, 1'b1, 5'd7, 32'h0000_0013, 5'd7, 32'h0000_0013});
        vecs.push_back('{"mtc0", 32'h4087_6000, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0,
                         32'hffff_ffff, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 32'h0000_0013});
        vecs.push_back('{"lui15", 32'h3c0f_1234, 30'h0, 32'h1234_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd15, 32'h1234_0000, 5'd15, 32'h1234_0000});
        vecs.push_back('{"slt16", 32'h0109_802a, 30'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b1, 1'b1, 5'd16, 32'h1, 5'd16, 32'h1});
        vecs.push_back('{"mult", 32'h0109_0018, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b0, 5'd0, 32'h0, 5'd16, 32'h1});
        vecs.push_back('{"badfn", 32'h0109_803f, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b0, 5'd0, 32'h0, 5'd16, 32'h1});
        vecs.push_back('{"beq", 32'h1109_0003, 30'h0, 32'hdead_beef, 32'h0, 32'h0, 32'h0, 32'h0,
                         1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 32'hffff_ff80});
        vecs.push_back('{"jalwrap", 32'h0c00_0000, 30'h3fff_ffff, 32'hdead_beef, 32'h0, 32'h0,
                         32'h0, 32'h0, 1'b1, 1'b1, 5'd31, 32'h0000_0004, 5'd31, 32'h0000_0004});

        // Reset with a competing write: the write must be suppressed.
        drive_nop();
        rst     = 1'b1;
        raddr1  = 5'd29;
        raddr2  = 5'd28;
        InstrW  = 32'h2408_0005;
        AluOutW = 32'h5;
        @(negedge clk);
        #2;
        check("rst.we", {31'h0, wb_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_nop();
        #2;
        check("rst.sp", rdata1, 32'h0000_2ffc);
        check("rst.gp", rdata2, 32'h0000_1800);
        raddr1 = 5'd5;
        raddr2 = 5'd8;
        #1;
        check("rst.r5", rdata1, 32'h0);
        check("rst.r8", rdata2, 32'h0);

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
        end

        // Mid-program reset concurrent with a write to $3.
        @(negedge clk);
        InstrW = 32'h0000_1810;
        HiOutW = 32'haaaa_aaaa;
        rst    = 1'b1;
        raddr1 = 5'd3;
        raddr2 = 5'd31;
        #2;
        check("midrst.we", {31'h0, wb_we}, 32'h0);
        check("midrst.pre3", rdata1, 32'h1111_1111);
        check("midrst.pre31", rdata2, 32'h0000_0004);
        @(negedge clk);
        rst = 1'b0;
        drive_nop();
        #2;
        check("midrst.r3", rdata1, 32'h0);
        check("midrst.r31", rdata2, 32'h0);
        raddr1 = 5'd29;
        raddr2 = 5'd8;
        #1;
        check("midrst.sp", rdata1, 32'h0000_2ffc);
        check("midrst.r8", rdata2, 32'h0);

        if (sb_q.size() != 0) begin
            check("sb.drain", sb_q.size(), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
